dmem_avmm_master: RTL

Avalon-MM master bridging the SCR1 core's 32-bit data-memory request/response port onto the 64-bit on-chip RAM slave in `de10lite_qsys`. It handles one transaction at a time and steers byte/half/word accesses onto the 64-bit data path with byte enables. It honours `waitrequest` and `readdatavalid`, and returns an error response for misaligned or timed-out accesses. It sits between the core and the Qsys interconnect, replacing direct memory wiring.

---
 rtl/dmem_avmm_pkg.sv | 45 ++++
 rtl/dmem_avmm_lane.sv | 49 ++++
 rtl/dmem_avmm_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_avmm_pkg.sv
// Shared types and constants for the SCR1 data-memory Avalon-MM bridge.
// Request width/command encodings, FSM states and lane enable bases.
package dmem_avmm_pkg;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2,
    W_BAD  = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_RD,
    S_RESP
  } state_e;

  localparam int TIMEOUT_W = 8;

  localparam logic [7:0] BE_BYTE = 8'h01;
  localparam logic [7:0] BE_HALF = 8'h03;
  localparam logic [7:0] BE_WORD = 8'h0F;

  function automatic logic misaligned(
    input width_e     w,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b1;
    unique case (w)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = a[0];
      W_WORD:  bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_avmm_lane.sv
// Byte-lane steering between the 32-bit core port and the 64-bit bus.
// Purely combinational: enables, replicated write data, steered read data.
module dmem_avmm_lane
  import dmem_avmm_pkg::*;
(
  input  width_e      width,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata_in,
  output logic [7:0]  be,
  output logic [63:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0] lane;
  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata     = '0;
    lane      = addr[2] ? rdata_in[63:32]
                        : rdata_in[31:0];
    shifted   = lane >> {addr[1:0], 3'b000};
    unique case (1'b1)
      (width == W_BYTE): begin
        be        = BE_BYTE << addr;
        wdata_rep = {8{wdata[7:0]}};
        rdata     = {24'b0, shifted[7:0]};
      end
      (width == W_HALF): begin
        be        = BE_HALF << addr;
        wdata_rep = {4{wdata[15:0]}};
        rdata     = {16'b0, shifted[15:0]};
      end
      (width == W_WORD): begin
        be        = BE_WORD << addr;
        wdata_rep = {2{wdata}};
        rdata     = shifted;
      end
      default: begin
        be        = '0;
        wdata_rep = '0;
        rdata     = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_avmm_master.sv
// SCR1 dmem port to 64-bit Avalon-MM master, one transaction at a time.
// Misaligned and timed-out accesses complete with an error response.
module dmem_avmm_master
  import dmem_avmm_pkg::*;
#(
  parameter int AVM_AW         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cmd,
  input  logic [1:0]        req_width,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [AVM_AW-1:0] avm_address,
  output logic [7:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [63:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state;
  cmd_e                 r_cmd;
  width_e               r_width;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [TIMEOUT_W-1:0] cnt;

  logic [7:0]  lane_be;
  logic [63:0] lane_wdata;
  logic [31:0] lane_rdata;

  dmem_avmm_lane u_lane (
    .width     (r_width),
    .addr      (r_addr[2:0]),
    .wdata     (r_wdata),
    .rdata_in  (avm_readdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata     (lane_rdata)
  );

  // Bus fields come from captured request, gated by the strobes.
  assign avm_address    = AVM_AW'({r_addr[31:3], 3'b000});
  assign avm_byteenable = (avm_read | avm_write) ? lane_be : '0;
  assign avm_writedata  = avm_write ? lane_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      r_cmd      <= CMD_RD;
      r_width    <= W_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      avm_read   <= 1'b0;
      avm_write  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_cmd      <= cmd_e'(req_cmd);
            r_width    <= width_e'(req_width);
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            cnt        <= '0;
            if (misaligned(width_e'(req_width),
                           req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= S_CMD;
              avm_read  <= (req_cmd == CMD_RD);
              avm_write <= (req_cmd == CMD_WR);
            end
          end
        end
        S_CMD: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (r_cmd == CMD_WR) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT_RD;
              cnt   <= '0;
            end
          end else if (cnt == TO_LAST) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_RD: begin
          if (avm_readdatavalid) begin
            resp_rdata <= lane_rdata;
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end else if (cnt == TO_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
